f1_reaction_timer: RTL and testbench

F1_REACTION_TIMER -- requirements
Module: f1_reaction_timer

---
 rtl/f1_pkg.sv | 21 ++
 rtl/f1_lfsr.sv | 19 +
 rtl/f1_reaction_timer.sv | 144 ++++++++++++++
 tb/tb_f1_reaction_timer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// Shared definitions for the F1 reaction timer: FSM states, LFSR geometry and feedback taps.
package f1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_TIMING,
        ST_DONE
    } f1_state_t;

    localparam int unsigned LFSR_W = 7;

    // x^7 + x^6 + 1: feedback from the two most significant stages
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'b110_0000;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/f1_lfsr.sv
// Free-running 7-bit Fibonacci LFSR used to pick the random lights-out delay.
module f1_lfsr
    import f1_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    // A zero seed would lock the register up, so it is replaced by 1
    always_ff @(posedge clk) begin
        if (rst)
            q <= (seed == '0) ? LFSR_W'(1) : seed;
        else
            q <= lfsr_next(q);
    end

endmodule

// File: rtl/f1_reaction_timer.sv
// F1 start-lights reaction timer: random delay after full lights, then times the driver's press.
// Optional feature macro: JUMP_START_EN (detect presses before lights-out as jump starts).
module f1_reaction_timer
    import f1_pkg::*;
#(
    parameter int unsigned        CNT_W     = 16,
    parameter logic [LFSR_W-1:0]  LFSR_SEED = 7'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             tick,
    input  logic [7:0]       lights_in,
    input  logic             btn,
    output logic             lights_off,
    output logic             react_valid,
    output logic [CNT_W-1:0] react_time,
    output logic             jump_start,
    output logic             timeout,
    output logic             busy
);

    f1_state_t         state, state_nxt;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] dly_cnt;
    logic [CNT_W-1:0]  cnt;
    logic              btn_q;
    logic              press;
    logic              jump_press;
    logic              arm;
    logic              finish;
    logic              fin_to;
    logic [CNT_W-1:0]  fin_time;

    f1_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    assign press = btn & ~btn_q;

`ifdef JUMP_START_EN
    assign jump_press = press && (state == ST_ARMED || state == ST_DELAY);

    always_ff @(posedge clk) begin
        if (rst || arm)
            jump_start <= 1'b0;
        else if (finish)
            jump_start <= jump_press;
    end
`else
    assign jump_press = 1'b0;
    assign jump_start = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        finish    = 1'b0;
        fin_to    = 1'b0;
        fin_time  = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_ARMED;
                    arm       = 1'b1;
                end
            end
            ST_ARMED: begin
                if (jump_press) begin
                    state_nxt = ST_DONE;
                    finish    = 1'b1;
                end else if (lights_in == 8'hFF) begin
                    state_nxt = ST_DELAY;
                end
            end
            ST_DELAY: begin
                // A jump start outranks a coincident delay expiry
                if (jump_press) begin
                    state_nxt = ST_DONE;
                    finish    = 1'b1;
                end else if (tick && dly_cnt == LFSR_W'(1)) begin
                    state_nxt = ST_TIMING;
                end
            end
            ST_TIMING: begin
                if (press) begin
                    state_nxt = ST_DONE;
                    finish    = 1'b1;
                    fin_time  = cnt;
                end else if (&cnt) begin
                    state_nxt = ST_DONE;
                    finish    = 1'b1;
                    fin_time  = '1;
                    fin_to    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q       <= 1'b0;
            react_valid <= 1'b0;
            react_time  <= '0;
            timeout     <= 1'b0;
            dly_cnt     <= '0;
            cnt         <= '0;
        end else begin
            btn_q       <= btn;
            react_valid <= finish;
            if (arm) begin
                react_time <= '0;
                timeout    <= 1'b0;
            end else if (finish) begin
                react_time <= fin_time;
                timeout    <= fin_to;
            end
            if (state == ST_ARMED && state_nxt == ST_DELAY)
                dly_cnt <= lfsr_q;
            else if (state == ST_DELAY && tick)
                dly_cnt <= dly_cnt - LFSR_W'(1);
            // Held at zero outside TIMING so the entry cycle reads 0
            if (state != ST_TIMING)
                cnt <= '0;
            else if (state_nxt == ST_TIMING)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign lights_off = (state == ST_TIMING);
    assign busy       = (state == ST_ARMED) || (state == ST_DELAY) || (state == ST_TIMING);

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Self-checking bench for f1_reaction_timer: randomized races against a spec-level model.
module tb_f1_reaction_timer;

    localparam logic [6:0] SEED = 7'h01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic        tick = 1'b0;
    logic [7:0]  lights_in = 8'h00;
    logic        btn = 1'b0;
    logic        btn4 = 1'b0;

    logic        lights_off, react_valid, jump_start, timeout, busy;
    logic [15:0] react_time;
    logic        lights_off4, react_valid4, jump_start4, timeout4, busy4;
    logic [3:0]  react_time4;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [6:0]  m;

    f1_reaction_timer #(.CNT_W(16), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .lights_in(lights_in), .btn(btn),
        .lights_off(lights_off), .react_valid(react_valid), .react_time(react_time),
        .jump_start(jump_start), .timeout(timeout), .busy(busy)
    );

    f1_reaction_timer #(.CNT_W(4), .LFSR_SEED(SEED)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .tick(tick), .lights_in(lights_in), .btn(btn4),
        .lights_off(lights_off4), .react_valid(react_valid4), .react_time(react_time4),
        .jump_start(jump_start4), .timeout(timeout4), .busy(busy4)
    );

    always #5 clk = ~clk;

    // Reference sequence: polynomial x^7+x^6+1, new bit = b7 xor b6, seeded on reset
    function automatic logic [6:0] poly_step(input logic [6:0] v);
        logic fb;
        fb = v[6] ^ v[5];
        return {v[5:0], fb};
    endfunction

    always @(posedge clk) m <= rst ? SEED : poly_step(m);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, present full lights, return the delay the DUT should have loaded
    task automatic launch(input bit use4, output int exp_delay);
        if (use4) start4 = 1'b1; else start = 1'b1;
        step();
        start = 1'b0;
        start4 = 1'b0;
        chk("armed_busy", use4 ? busy4 : busy, 1);
        chk("armed_clr_time", use4 ? 32'(react_time4) : 32'(react_time), 0);
        chk("armed_clr_flags", {use4 ? timeout4 : timeout, use4 ? jump_start4 : jump_start}, 0);
        lights_in = 8'hFF;
        exp_delay = int'(m);
        step();
        lights_in = 8'(($urandom_range(0, 254)));
        chk("delay_busy", use4 ? busy4 : busy, 1);
        chk("delay_lights_off", use4 ? lights_off4 : lights_off, 0);
    endtask

    task automatic run_delay(input bit use4, input int exp_delay);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            tick = 1'($urandom_range(0, 1));
            step();
            if (tick) n++;
            tick = 1'b0;
            if (use4 ? lights_off4 : lights_off) done = 1'b1;
        end
        chk("lights_off_reached", done, 1);
        chk("delay_ticks", n, exp_delay);
        chk("delay_range", (n >= 1 && n <= 127), 1);
    endtask

    // Entry cycle has count 0; press when count equals r
    task automatic finish_race(input int r, input bit poke_start);
        for (int i = 0; i < r; i++) begin
            if (poke_start && i == 1) start = 1'b1;
            step();
            start = 1'b0;
        end
        btn = 1'b1;
        step();
        chk("result_valid", react_valid, 1);
        chk("result_time", react_time, r);
        chk("result_flags", {timeout, jump_start, lights_off, busy}, 0);
        btn = 1'b0;
        step();
        chk("valid_single", react_valid, 0);
        chk("time_hold", react_time, r);
    endtask

    initial begin
        int d;
        int r;
        bit seen;

        repeat (3) step();
        rst = 1'b0;
        chk("rst_outputs", {lights_off, react_valid, jump_start, timeout, busy}, 0);
        chk("rst_time", react_time, 0);
        chk("rst_outputs4", {lights_off4, react_valid4, jump_start4, timeout4, busy4, react_time4}, 0);
        repeat (int'($urandom_range(1, 20))) step();

        // Normal race, press 37 cycles after lights-out
        launch(1'b0, d);
        run_delay(1'b0, d);
        finish_race(37, 1'b0);

        // Random races, including a press on the entry cycle and an ignored start
        for (int k = 0; k < 4; k++) begin
            r = (k == 0) ? 0 : int'($urandom_range(1, 400));
            repeat (int'($urandom_range(0, 9))) step();
            launch(1'b0, d);
            run_delay(1'b0, d);
            finish_race(r, (k == 2 && r > 2));
        end

        // Press during DELAY
        launch(1'b0, d);
        btn = 1'b1;
        step();
        btn = 1'b0;
`ifdef JUMP_START_EN
        chk("jump_valid", react_valid, 1);
        chk("jump_flag", jump_start, 1);
        chk("jump_time", react_time, 0);
        chk("jump_lights", {lights_off, busy, timeout}, 0);
        step();
        chk("jump_valid_single", react_valid, 0);
`else
        chk("early_press_ignored", react_valid, 0);
        chk("early_press_busy", busy, 1);
        chk("early_press_lights", lights_off, 0);
        run_delay(1'b0, d);
        finish_race(int'($urandom_range(1, 60)), 1'b0);
`endif

        // Held button: held from before start through lights-out, then re-pressed
        btn = 1'b1;
        step();
        launch(1'b0, d);
        run_delay(1'b0, d);
        step();
        step();
        chk("held_no_result", react_valid, 0);
        chk("held_still_timing", lights_off, 1);
        btn = 1'b0;
        step();
        step();
        step();
        btn = 1'b1;
        step();
        btn = 1'b0;
        chk("held_valid", react_valid, 1);
        chk("held_time", react_time, 5);

        // Timeout on the narrow instance
        launch(1'b1, d);
        run_delay(1'b1, d);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            if (react_valid4) seen = 1'b1;
        end
        chk("to_valid_seen", seen, 1);
        chk("to_time", react_time4, 4'hF);
        chk("to_flag", timeout4, 1);
        chk("to_jump", jump_start4, 0);
        chk("to_lights", lights_off4, 0);
        step();
        chk("to_valid_single", react_valid4, 0);
        chk("to_hold", {timeout4, react_time4}, 5'h1F);

        // Reset in the middle of TIMING
        launch(1'b0, d);
        run_delay(1'b0, d);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_outputs", {lights_off, react_valid, jump_start, timeout, busy}, 0);
        chk("midrst_time", react_time, 0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (react_valid || busy) seen = 1'b1;
        end
        chk("midrst_quiet", seen, 0);
        launch(1'b0, d);
        run_delay(1'b0, d);
        finish_race(int'($urandom_range(1, 100)), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
